// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU: opcodes, sequencer states, ALU ops, IR field slices.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_MOV  = 4'h6,
    OP_LDI  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_PASSB
  } alu_op_t;

  // Instruction layout: opcode[7:4], rd[3:2], rs[1:0]
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RD_HI  = 3;
  localparam int RD_LO  = 2;
  localparam int RS_HI  = 1;
  localparam int RS_LO  = 0;

  // Map an ALU-class opcode onto the ALU operation; non-ALU opcodes never reach EXEC.
  function automatic alu_op_t alu_op_of(input logic [3:0] opc);
    case (opc)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_MOV:  return ALU_PASSB;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; mod-256 arithmetic, no carry out.
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  output logic [7:0] y,
  output logic       zero
);

  // Select the result for the requested operation
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        RegisterData1,
  output logic [1:0]        RegisterData2,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  output logic              RegWrite_Enable,
  output logic [1:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              zero_flag,
  output logic              halted
);

  seq_state_t        r_state, w_next;
  logic [DATA_W-1:0] r_pc, r_ir, r_result;
  logic              r_zero;
  logic [3:0]        w_opc;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_zero;

  assign w_opc = r_ir[OPC_HI:OPC_LO];

  alu8 u_alu (
    .a    (Data1),
    .b    (Data2),
    .op   (alu_op_of(w_opc)),
    .y    (w_alu_y),
    .zero (w_alu_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state decode and strobes; reset forces strobes low in its own cycle
  always_comb begin
    w_next          = r_state;
    mem_req         = 1'b0;
    RegWrite_Enable = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_opc)
          OP_LDI, OP_JMP, OP_JZ:                        w_next = S_IMM;
          OP_HALT:                                      w_next = S_HALT;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: w_next = S_EXEC;
          default:                                      w_next = S_FETCH;
        endcase
      end
      S_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) w_next = (w_opc == OP_LDI) ? S_WB : S_FETCH;
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        RegWrite_Enable = 1'b1;
        w_next          = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      mem_req         = 1'b0;
      RegWrite_Enable = 1'b0;
    end
  end

  // Datapath: PC, IR, result and Z updates per state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 8'd1;
          end
        end
        S_IMM: begin
          if (mem_ready) begin
            r_pc <= r_pc + 8'd1;
            case (w_opc)
              OP_LDI:  r_result <= mem_rdata;
              OP_JMP:  r_pc <= mem_rdata;
              OP_JZ:   if (r_zero) r_pc <= mem_rdata;
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          r_result <= w_alu_y;
          r_zero   <= w_alu_zero;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr      = r_pc;
  assign RegisterData1 = r_ir[RD_HI:RD_LO];
  assign RegisterData2 = r_ir[RS_HI:RS_LO];
  assign WriteRegister = r_ir[RD_HI:RD_LO];
  assign WriteData     = r_result;
  assign zero_flag     = r_zero;
  assign halted        = (r_state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a byte memory and a 4-entry register file.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [1:0] RegisterData1, RegisterData2, WriteRegister;
  logic [7:0] Data1, Data2, WriteData;
  logic       RegWrite_Enable, zero_flag, halted;

  logic [7:0] mem [256];
  logic [7:0] regs [4];

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int we_b2b  = 0;
  logic we_prev = 1'b0;

  control_sequencer #(.RESET_PC(8'h00), .DATA_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .RegisterData1   (RegisterData1),
    .RegisterData2   (RegisterData2),
    .Data1           (Data1),
    .Data2           (Data2),
    .RegWrite_Enable (RegWrite_Enable),
    .WriteRegister   (WriteRegister),
    .WriteData       (WriteData),
    .zero_flag       (zero_flag),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign Data1     = regs[RegisterData1];
  assign Data2     = regs[RegisterData2];

  // Register file model: write on the edge that ends WB
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (RegWrite_Enable) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Track write strobes and any back-to-back pulses
  always @(posedge clk) begin
    if (RegWrite_Enable) we_cnt <= we_cnt + 1;
    if (RegWrite_Enable && we_prev) we_b2b <= we_b2b + 1;
    we_prev <= RegWrite_Enable;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // Program
    mem[8'h00] = 8'h74; mem[8'h01] = 8'h2A;  // LDI r1,#2A
    mem[8'h02] = 8'h78; mem[8'h03] = 8'h20;  // LDI r2,#20
    mem[8'h04] = 8'h74; mem[8'h05] = 8'hF0;  // LDI r1,#F0
    mem[8'h06] = 8'h16;                      // ADD r1,r2 -> 10
    mem[8'h07] = 8'h25;                      // SUB r1,r1 -> 00, Z=1
    mem[8'h08] = 8'h90; mem[8'h09] = 8'h40;  // JZ 40 (taken)
    mem[8'h40] = 8'h16;                      // ADD r1,r2 -> 20, Z=0
    mem[8'h41] = 8'h80; mem[8'h42] = 8'h10;  // JMP 10
    mem[8'h10] = 8'h90; mem[8'h11] = 8'h40;  // JZ 40 (not taken)
    mem[8'h12] = 8'h0C;                      // NOP with rd=3 (wait-state test)
    mem[8'h13] = 8'h16;                      // ADD, interrupted by reset

    mem_ready = 1'b1;
    reset     = 1'b1;
    tick();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, RegWrite_Enable}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pc", {24'd0, mem_addr}, 32'h00);
    chk("rst_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("rst_halt", {31'd0, halted}, 32'd0);
    chk("rst_z", {31'd0, zero_flag}, 32'd0);
    chk("rst_wd", {24'd0, WriteData}, 32'h00);

    // LDI r1,#2A: FETCH, DECODE, IMM -> WB
    tick(3);
    chk("ldi_we", {31'd0, RegWrite_Enable}, 32'd1);
    chk("ldi_wr", {30'd0, WriteRegister}, 32'd1);
    chk("ldi_wd", {24'd0, WriteData}, 32'h2A);
    chk("ldi_pc", {24'd0, mem_addr}, 32'h02);
    chk("ldi_req", {31'd0, mem_req}, 32'd0);
    tick();
    tick(4);
    tick(4);
    chk("ldi2_pc", {24'd0, mem_addr}, 32'h06);

    // ADD r1,r2 with wrap
    tick(3);
    chk("add_we", {31'd0, RegWrite_Enable}, 32'd1);
    chk("add_wd", {24'd0, WriteData}, 32'h10);
    chk("add_z", {31'd0, zero_flag}, 32'd0);
    tick();

    // SUB r1,r1
    tick(3);
    chk("sub_wd", {24'd0, WriteData}, 32'h00);
    chk("sub_z", {31'd0, zero_flag}, 32'd1);
    tick();
    chk("sub_pc", {24'd0, mem_addr}, 32'h08);

    // JZ taken
    tick(3);
    chk("jz_t_pc", {24'd0, mem_addr}, 32'h40);
    chk("jz_t_req", {31'd0, mem_req}, 32'd1);

    // ADD -> 0x20, Z=0
    tick(3);
    chk("add2_wd", {24'd0, WriteData}, 32'h20);
    chk("add2_z", {31'd0, zero_flag}, 32'd0);
    tick();

    // JMP 10
    tick(3);
    chk("jmp_pc", {24'd0, mem_addr}, 32'h10);

    // JZ not taken
    tick(3);
    chk("jz_nt_pc", {24'd0, mem_addr}, 32'h12);

    // Wait states in FETCH
    mem_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", {24'd0, mem_addr}, 32'h12);
      chk("wait_ir", {30'd0, RegisterData1}, 32'd0);
    end
    mem_ready = 1'b1;
    tick();
    chk("wait_ir_load", {30'd0, RegisterData1}, 32'd3);
    chk("wait_dec_req", {31'd0, mem_req}, 32'd0);
    chk("wait_pc_inc", {24'd0, mem_addr}, 32'h13);
    tick();
    chk("nop_fetch", {31'd0, mem_req}, 32'd1);

    // Reset in EXEC of an ADD
    tick(2);
    chk("exec_we", {31'd0, RegWrite_Enable}, 32'd0);
    reset = 1'b1;
    mem[8'h00] = 8'hF0;  // HALT at reset vector for the next test
    #1;
    chk("midrst_we", {31'd0, RegWrite_Enable}, 32'd0);
    tick();
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_pc", {24'd0, mem_addr}, 32'h00);
    chk("midrst_fetch", {31'd0, mem_req}, 32'd1);
    chk("we_count", we_cnt, 32'd6);

    // HALT
    tick(2);
    chk("halt", {31'd0, halted}, 32'd1);
    for (int h = 0; h < 10; h++) begin
      tick();
      chk("halt_hold", {30'd0, mem_req, halted}, 32'b01);
    end

    // NOP at 0xFF wraps to 0x00
    mem[8'h00] = 8'h80; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("unhalt", {31'd0, halted}, 32'd0);
    tick(3);
    chk("jmp_ff", {24'd0, mem_addr}, 32'hFF);
    tick(2);
    chk("wrap_pc", {24'd0, mem_addr}, 32'h00);
    chk("wrap_req", {31'd0, mem_req}, 32'd1);

    chk("we_total", we_cnt, 32'd6);
    chk("we_b2b", we_b2b, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
